// File: rtl/gowin_ddr_pkg.sv
// gowin_ddr_pkg
//   Shared definitions for the IDES8 word-alignment controller: the per-lane
//   state encoding, its width, and the default training word.
//   Optional feature macro: DDR_ALIGN_DLY_EN (adds the IODELAY tap-step state).
`timescale 1ns/1ps
package gowin_ddr_pkg;

   localparam int          STATE_W         = 3;
   localparam logic [7:0]  DEFAULT_PATTERN = 8'hB4;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_CHECK  = 3'd2,
      ST_SLIP   = 3'd3,
`ifdef DDR_ALIGN_DLY_EN
      ST_STEP   = 3'd4,
`endif
      ST_LOCKED = 3'd5,
      ST_FAIL   = 3'd6
   } lane_state_e;

endpackage

// File: rtl/gowin_ddr_lane_align.sv
// gowin_ddr_lane_align
//   Alignment/training FSM for one deserialised lane. Bitslips the IDES8
//   until the lane word equals PATTERN for MATCH_CNT consecutive cycles; with
//   DDR_ALIGN_DLY_EN defined, also steps the IODELAY tap after every full
//   bitslip sweep.
// Ports
//   pclk_i      parallel clock
//   resetn_i    asynchronous active-low reset
//   start_i     (re)start training
//   word_i      this lane's IDES8 parallel word
//   calib_o     IDES8 CALIB pulse (one bitslip)
//   dly_sdtap_o IODELAY dynamic tap select
//   dly_value_o IODELAY VALUE pulse (one tap step)
//   dly_setn_o  IODELAY direction (0 = increment)
//   locked_o    lane aligned
//   fail_o      search space exhausted
// Macro: DDR_ALIGN_DLY_EN
`timescale 1ns/1ps
module gowin_ddr_lane_align
   import gowin_ddr_pkg::*;
#(
   parameter int               RATIO      = 8,
   parameter logic [RATIO-1:0] PATTERN    = RATIO'(DEFAULT_PATTERN),
   parameter int               SETTLE_CYC = 4,
   parameter int               MATCH_CNT  = 4
`ifdef DDR_ALIGN_DLY_EN
   ,parameter int              TAP_MAX    = 31
`endif
) (
   input  logic             pclk_i,
   input  logic             resetn_i,
   input  logic             start_i,
   input  logic [RATIO-1:0] word_i,
   output logic             calib_o,
   output logic             dly_sdtap_o,
   output logic             dly_value_o,
   output logic             dly_setn_o,
   output logic             locked_o,
   output logic             fail_o
);

   localparam int SLIP_W   = $clog2(RATIO);
   localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);
   localparam int MATCH_W  = $clog2(MATCH_CNT + 1);

   localparam logic [SLIP_W-1:0]   SLIP_LAST   = SLIP_W'(RATIO - 1);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
   localparam logic [MATCH_W-1:0]  MATCH_LAST  = MATCH_W'(MATCH_CNT - 1);

   lane_state_e         state_q,  state_d;
   logic [SLIP_W-1:0]   slip_q,   slip_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic [MATCH_W-1:0]  match_q,  match_d;
   logic                locked_q, locked_d;
   logic                fail_q,   fail_d;
`ifdef DDR_ALIGN_DLY_EN
   localparam int               TAP_W    = $clog2(TAP_MAX + 1);
   localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAP_MAX);
   logic [TAP_W-1:0]    tap_q,    tap_d;
`endif

   always_ff @(posedge pclk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q  <= ST_IDLE;
         slip_q   <= '0;
         settle_q <= '0;
         match_q  <= '0;
         locked_q <= 1'b0;
         fail_q   <= 1'b0;
`ifdef DDR_ALIGN_DLY_EN
         tap_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         slip_q   <= slip_d;
         settle_q <= settle_d;
         match_q  <= match_d;
         locked_q <= locked_d;
         fail_q   <= fail_d;
`ifdef DDR_ALIGN_DLY_EN
         tap_q    <= tap_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      slip_d   = slip_q;
      settle_d = settle_q;
      match_d  = match_q;
`ifdef DDR_ALIGN_DLY_EN
      tap_d    = tap_q;
`endif
      if (start_i) begin
         // Restart from any state; the tap is deliberately kept so the sweep
         // resumes where it left off.
         state_d  = ST_SETTLE;
         slip_d   = '0;
         settle_d = '0;
         match_d  = '0;
      end else begin
         case (state_q)
            ST_SETTLE: begin
               if (settle_q == SETTLE_LAST) begin
                  state_d  = ST_CHECK;
                  settle_d = '0;
                  match_d  = '0;
               end else begin
                  settle_d = settle_q + SETTLE_W'(1);
               end
            end
            ST_CHECK: begin
               if (word_i == PATTERN) begin
                  if (match_q == MATCH_LAST) state_d = ST_LOCKED;
                  else                       match_d = match_q + MATCH_W'(1);
               end else begin
                  match_d = '0;
                  // One more slip after RATIO-1 would return to the original phase.
                  if (slip_q != SLIP_LAST) begin
                     state_d = ST_SLIP;
                  end else begin
`ifdef DDR_ALIGN_DLY_EN
                     if (tap_q != TAP_LAST) state_d = ST_STEP;
                     else                   state_d = ST_FAIL;
`else
                     state_d = ST_FAIL;
`endif
                  end
               end
            end
            ST_SLIP: begin
               slip_d   = slip_q + SLIP_W'(1);
               settle_d = '0;
               state_d  = ST_SETTLE;
            end
`ifdef DDR_ALIGN_DLY_EN
            ST_STEP: begin
               tap_d    = tap_q + TAP_W'(1);
               slip_d   = '0;
               settle_d = '0;
               state_d  = ST_SETTLE;
            end
`endif
            default: ;
         endcase
      end
      // Status is registered one cycle behind the state, but start clears it
      // immediately so it falls the cycle after start.
      locked_d = !start_i && (state_q == ST_LOCKED);
      fail_d   = !start_i && (state_q == ST_FAIL);
   end

   assign calib_o  = (state_q == ST_SLIP);
   assign locked_o = locked_q;
   assign fail_o   = fail_q;
`ifdef DDR_ALIGN_DLY_EN
   assign dly_sdtap_o = (state_q != ST_IDLE);
   assign dly_value_o = (state_q == ST_STEP);
   assign dly_setn_o  = 1'b0;
`else
   assign dly_sdtap_o = 1'b0;
   assign dly_value_o = 1'b0;
   assign dly_setn_o  = 1'b0;
`endif

endmodule

// File: rtl/gowin_ddr_align.sv
// gowin_ddr_align
//   Multi-lane word-alignment and delay-training controller for IDES8 inputs.
//   One gowin_ddr_lane_align per lane, a registered copy of the parallel
//   words, and the done/error reductions.
// Ports
//   pclk_i         parallel clock (sole clock)
//   resetn_i       asynchronous active-low reset
//   start_i        1-cycle pulse, (re)starts training on all lanes
//   q_in_i         IDES8 Q words, lane i = [i*RATIO +: RATIO]
//   q_out_o        q_in_i registered (1-cycle latency)
//   calib_o        per-lane IDES8 CALIB
//   dly_sdtap_o    per-lane IODELAY SDTAP
//   dly_value_o    per-lane IODELAY VALUE
//   dly_setn_o     per-lane IODELAY SETN
//   lane_locked_o  per-lane lock
//   lane_fail_o    per-lane failure
//   done_o         every lane locked or failed
//   error_o        any lane failed
// Macro: DDR_ALIGN_DLY_EN enables the IODELAY tap sweep.
`timescale 1ns/1ps
module gowin_ddr_align
   import gowin_ddr_pkg::*;
#(
   parameter int               LANES      = 2,
   parameter int               RATIO      = 8,
   parameter logic [RATIO-1:0] PATTERN    = RATIO'(DEFAULT_PATTERN),
   parameter int               SETTLE_CYC = 4,
   parameter int               MATCH_CNT  = 4
`ifdef DDR_ALIGN_DLY_EN
   ,parameter int              TAP_MAX    = 31
`endif
) (
   input  logic                   pclk_i,
   input  logic                   resetn_i,
   input  logic                   start_i,
   input  logic [LANES*RATIO-1:0] q_in_i,
   output logic [LANES*RATIO-1:0] q_out_o,
   output logic [LANES-1:0]       calib_o,
   output logic [LANES-1:0]       dly_sdtap_o,
   output logic [LANES-1:0]       dly_value_o,
   output logic [LANES-1:0]       dly_setn_o,
   output logic [LANES-1:0]       lane_locked_o,
   output logic [LANES-1:0]       lane_fail_o,
   output logic                   done_o,
   output logic                   error_o
);

   logic [LANES*RATIO-1:0] q_out_q;

   always_ff @(posedge pclk_i or negedge resetn_i) begin
      if (!resetn_i) q_out_q <= '0;
      else           q_out_q <= q_in_i;
   end

   assign q_out_o = q_out_q;

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      gowin_ddr_lane_align #(
         .RATIO      (RATIO),
         .PATTERN    (PATTERN),
         .SETTLE_CYC (SETTLE_CYC),
         .MATCH_CNT  (MATCH_CNT)
`ifdef DDR_ALIGN_DLY_EN
         ,.TAP_MAX   (TAP_MAX)
`endif
      ) u_lane (
         .pclk_i      (pclk_i),
         .resetn_i    (resetn_i),
         .start_i     (start_i),
         .word_i      (q_in_i[gi*RATIO +: RATIO]),
         .calib_o     (calib_o[gi]),
         .dly_sdtap_o (dly_sdtap_o[gi]),
         .dly_value_o (dly_value_o[gi]),
         .dly_setn_o  (dly_setn_o[gi]),
         .locked_o    (lane_locked_o[gi]),
         .fail_o      (lane_fail_o[gi])
      );
   end

   assign done_o  = &(lane_locked_o | lane_fail_o);
   assign error_o = |lane_fail_o;

endmodule

// File: tb/tb_gowin_ddr_align.sv
`timescale 1ns/1ps
module tb_gowin_ddr_align;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic [15:0] q_in, q_out, q_model, ovr_val;
   logic        ovr;
   logic [1:0]  calib, sdtap, value, setn, locked, fail;
   logic        done, error;

   always #5 clk = ~clk;

   gowin_ddr_align dut (
      .pclk_i        (clk),
      .resetn_i      (resetn),
      .start_i       (start),
      .q_in_i        (q_in),
      .q_out_o       (q_out),
      .calib_o       (calib),
      .dly_sdtap_o   (sdtap),
      .dly_value_o   (value),
      .dly_setn_o    (setn),
      .lane_locked_o (locked),
      .lane_fail_o   (fail),
      .done_o        (done),
      .error_o       (error)
   );

`ifdef DDR_ALIGN_DLY_EN
   localparam logic [1:0] SDTAP_RUN  = 2'b11;
   localparam int         FAIL_CYC   = 1536;
   localparam int         FAIL_SLIPS = 224;
`else
   localparam logic [1:0] SDTAP_RUN  = 2'b00;
   localparam int         FAIL_CYC   = 48;
   localparam int         FAIL_SLIPS = 7;
`endif

   // IDES/IODELAY model: word = PATTERN rotated by (phase + slips) mod 8;
   // zero when the lane is forced to never match or sits at a wrong tap.
   int phase [2];
   int mtap [2];
   bit nomatch [2];
   logic mon_clr;

   int slips [2], taps [2], calib_cnt [2], value_cnt [2], since_val [2], gap_cnt [2];
   bit seen [2];
   logic [1:0] calib_prev;
   int width_bad, gap_bad, vp_bad, setn_bad, both_bad;

   function automatic logic [7:0] lane_word(input int ph, input int sl, input int tp,
                                             input int mt, input bit nm);
      logic [7:0] p;
      int r;
      p = 8'hB4;
      r = (ph + sl) % 8;
      if (nm) return 8'h00;
      if (mt >= 0 && tp != mt) return 8'h00;
      return (p << r) | (p >> (8 - r));
   endfunction

   assign q_model = {lane_word(phase[1], slips[1], taps[1], mtap[1], nomatch[1]),
                     lane_word(phase[0], slips[0], taps[0], mtap[0], nomatch[0])};
   assign q_in = ovr ? ovr_val : q_model;

   always @(posedge clk) begin
      if (mon_clr) begin
         for (int l = 0; l < 2; l++) begin
            slips[l] <= 0; taps[l] <= 0; calib_cnt[l] <= 0; value_cnt[l] <= 0;
            since_val[l] <= 0; gap_cnt[l] <= 0; seen[l] <= 1'b0;
         end
         calib_prev <= 2'b00;
         width_bad <= 0; gap_bad <= 0; vp_bad <= 0; setn_bad <= 0; both_bad <= 0;
      end else begin
         calib_prev <= calib;
         for (int l = 0; l < 2; l++) begin
            if (calib[l]) begin
               slips[l]     <= slips[l] + 1;
               calib_cnt[l] <= calib_cnt[l] + 1;
               since_val[l] <= since_val[l] + 1;
               if (calib_prev[l]) width_bad <= width_bad + 1;
               if (seen[l] && gap_cnt[l] < 5) gap_bad <= gap_bad + 1;
               seen[l]    <= 1'b1;
               gap_cnt[l] <= 0;
            end else begin
               gap_cnt[l] <= gap_cnt[l] + 1;
            end
            if (value[l]) begin
               taps[l]      <= taps[l] + 1;
               value_cnt[l] <= value_cnt[l] + 1;
               if (since_val[l] != 7) vp_bad <= vp_bad + 1;
               since_val[l] <= 0;
               if (calib[l]) both_bad <= both_bad + 1;
            end
            if (setn[l]) setn_bad <= setn_bad + 1;
         end
      end
   end

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn  = 1'b0;
      start   = 1'b0;
      mon_clr = 1'b1;
      repeat (2) tick();
      resetn = 1'b1;
      tick();
      mon_clr = 1'b0;
   endtask

   task automatic start_pulse();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Returns the edge count after start at which done was first seen high.
   task automatic run_until_done(input int budget, output int cycles);
      cycles = 0;
      while (!done && cycles < budget) begin
         tick();
         cycles++;
      end
   endtask

   initial begin
      int c;
      resetn = 1'b0; start = 1'b0; ovr = 1'b0; ovr_val = 16'h0000; mon_clr = 1'b1;
      phase[0] = 0; phase[1] = 0; mtap[0] = -1; mtap[1] = -1;
      nomatch[0] = 1'b0; nomatch[1] = 1'b0;
      #2;
      chk("rst_q_out", q_out, 16'h0000);
      chk("rst_calib", calib, 2'b00);
      chk("rst_dly", {sdtap, value, setn}, 6'b000000);
      chk("rst_locked", locked, 2'b00);
      chk("rst_fail", fail, 2'b00);
      chk("rst_done_err", {done, error}, 2'b00);
      repeat (2) tick();
      resetn = 1'b1;
      tick();
      mon_clr = 1'b0;

      // q_out is q_in delayed by one cycle
      ovr = 1'b1; ovr_val = 16'h1234;
      #1 chk("qout_hold", q_out, 16'hB4B4);
      tick(); chk("qout_1234", q_out, 16'h1234);
      ovr_val = 16'hA55A;
      #1 chk("qout_hold2", q_out, 16'h1234);
      tick(); chk("qout_a55a", q_out, 16'hA55A);
      ovr = 1'b0;
      tick(); chk("qout_model", q_out, 16'hB4B4);

      // 1: both lanes aligned
      start_pulse();
      chk("s1_done_low", done, 1'b0);
      chk("s1_sdtap", sdtap, SDTAP_RUN);
      run_until_done(100, c);
      chk("s1_lock_cycle", c, 9);
      chk("s1_locked", locked, 2'b11);
      chk("s1_error", error, 1'b0);
      chk("s1_no_calib", calib_cnt[0] + calib_cnt[1], 0);

      // 2: lane0 needs 3 slips
      do_reset();
      phase[0] = 5;
      start_pulse();
      run_until_done(200, c);
      chk("s2_lock_cycle", c, 27);
      chk("s2_locked", locked, 2'b11);
      chk("s2_calib0", calib_cnt[0], 3);
      chk("s2_calib1", calib_cnt[1], 0);
      chk("s2_width", width_bad, 0);
      chk("s2_gap", gap_bad, 0);

`ifdef DDR_ALIGN_DLY_EN
      // 3: lane0 only matches at tap 5
      do_reset();
      phase[0] = 5; mtap[0] = 5;
      start_pulse();
      chk("s3_sdtap", sdtap, 2'b11);
      run_until_done(1000, c);
      chk("s3_lock_cycle", c, 249);
      chk("s3_locked", locked, 2'b11);
      chk("s3_values", value_cnt[0], 5);
      chk("s3_calibs", calib_cnt[0], 35);
      chk("s3_slips_per_tap", vp_bad, 0);
      chk("s3_setn", setn_bad, 0);
      chk("s3_overlap", both_bad, 0);
      mtap[0] = -1;
`endif

      // 4: lane0 never matches
      do_reset();
      phase[0] = 0; nomatch[0] = 1'b1;
      start_pulse();
      run_until_done(3000, c);
      chk("s4_fail_cycle", c, FAIL_CYC);
      chk("s4_fail", fail, 2'b01);
      chk("s4_locked", locked, 2'b10);
      chk("s4_error_done", {error, done}, 2'b11);
      chk("s4_calibs", calib_cnt[0], FAIL_SLIPS);
`ifdef DDR_ALIGN_DLY_EN
      chk("s4_values", value_cnt[0], 31);
      chk("s4_overlap", both_bad, 0);
`endif
      nomatch[0] = 1'b0;

      // 5: asynchronous reset in SETTLE
      do_reset();
      start_pulse();
      tick();
      chk("s5_pre_qout", q_out, 16'hB4B4);
      chk("s5_pre_sdtap", sdtap, SDTAP_RUN);
      #2 resetn = 1'b0;
      #1;
      chk("s5_async_qout", q_out, 16'h0000);
      chk("s5_async_dly", sdtap, 2'b00);
      chk("s5_async_stat", {locked, fail, done, error}, 6'b000000);
      tick();
      resetn = 1'b1;
      tick();
      start_pulse();
      run_until_done(100, c);
      chk("s5_relock_cycle", c, 9);
      chk("s5_relocked", locked, 2'b11);

      // 6: restart while locked with lane0 shifted by two
      mon_clr = 1'b1;
      tick();
      mon_clr = 1'b0;
      phase[0] = 6;
      start_pulse();
      chk("s6_locked_drop", locked, 2'b00);
      chk("s6_done_drop", done, 1'b0);
      run_until_done(100, c);
      chk("s6_lock_cycle", c, 21);
      chk("s6_calib0", calib_cnt[0], 2);
      chk("s6_calib1", calib_cnt[1], 0);
      chk("s6_locked", locked, 2'b11);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
